// File: rtl/csa_pkg.sv
// Shared types, constants and helpers for the pipelined carry-select adder.
package csa_pkg;

   // Default segment width; one pipeline stage per segment.
   localparam int CSA_DEFAULT_BLOCK = 8;

   // Per-stage control state. The partial sum and the remaining operand bits
   // are WIDTH-dependent, so they sit beside this struct as parameter-sized
   // arrays in the top rather than inside it.
   typedef struct packed {
      logic valid;  // stage holds a live transaction (not a bubble)
      logic carry;  // carry out of this stage's segment
   } csa_stage_t;

   // Pipeline depth; a bad BLOCK is caught separately at elaboration.
   function automatic int calc_num_blk(input int width, input int block);
      if (block < 1) return 1;
      return width / block;
   endfunction

endpackage

// File: rtl/csa_select_block.sv
// One carry-select segment: two ripple chains (carry-in 0 and 1) computed in
// parallel, then a 2:1 select on the real incoming carry. Purely combinational.
module csa_select_block #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout
);

   logic [BLOCK-1:0] sum0;
   logic [BLOCK-1:0] sum1;
   logic             c0;
   logic             c1;

   // Dual ripple chains, one assuming carry-in 0 and one assuming carry-in 1.
   always_comb begin
      // NOTE: blocking assignments are required here; c0/c1 carry the ripple
      // from one loop iteration to the next within the same evaluation.
      sum0 = '0;
      sum1 = '0;
      c0   = 1'b0;
      c1   = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
         sum0[i] = a[i] ^ b[i] ^ c0;
         c0      = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
         sum1[i] = a[i] ^ b[i] ^ c1;
         c1      = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
      end
   end

   // Late select on the incoming carry.
   assign sum  = cin ? sum1 : sum0;
   assign cout = cin ? c1   : c0;

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder with a valid/ready stream interface.
// One register stage per BLOCK-bit segment; latency NUM_BLK cycles.
// Optional macro CSA_SUB_EN adds in_sub: computes A + ~B + 1 when set.
module pipelined_carry_select_adder
   import csa_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BLOCK = CSA_DEFAULT_BLOCK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef CSA_SUB_EN
   input  logic             in_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NUM_BLK = calc_num_blk(WIDTH, BLOCK);

   if (BLOCK < 1) begin : g_bad_block
      $error("pipelined_carry_select_adder: BLOCK must be >= 1");
   end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
      $error("pipelined_carry_select_adder: WIDTH must be a multiple of BLOCK");
   end

   // Effective operand B and carry-in; subtraction folds into the ingress.
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
`ifdef CSA_SUB_EN
   assign b_eff   = in_sub ? ~in_b : in_b;
   assign cin_eff = in_sub | in_cin;
`else
   assign b_eff   = in_b;
   assign cin_eff = in_cin;
`endif

   // Whole pipeline advances together whenever the output slot can move.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   csa_stage_t       st_q  [NUM_BLK];
   logic [WIDTH-1:0] sum_q [NUM_BLK];
   logic [WIDTH-1:0] a_q   [NUM_BLK];
   logic [WIDTH-1:0] b_q   [NUM_BLK];
   logic             ovf_q;

   for (genvar k = 0; k < NUM_BLK; k++) begin : g_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] sum_src;
      logic             c_src;
      logic             v_src;
      logic [BLOCK-1:0] seg_sum;
      logic             seg_cout;
      logic [WIDTH-1:0] sum_nxt;

      if (k == 0) begin : g_head
         assign a_src   = in_a;
         assign b_src   = b_eff;
         assign sum_src = '0;
         assign c_src   = cin_eff;
         assign v_src   = in_valid;
      end else begin : g_link
         assign a_src   = a_q[k-1];
         assign b_src   = b_q[k-1];
         assign sum_src = sum_q[k-1];
         assign c_src   = st_q[k-1].carry;
         assign v_src   = st_q[k-1].valid;
      end

      csa_select_block #(.BLOCK(BLOCK)) u_blk (
         .a    (a_src[k*BLOCK +: BLOCK]),
         .b    (b_src[k*BLOCK +: BLOCK]),
         .cin  (c_src),
         .sum  (seg_sum),
         .cout (seg_cout)
      );

      // Merge this segment's result into the travelling partial sum.
      always_comb begin
         sum_nxt                    = sum_src;
         sum_nxt[k*BLOCK +: BLOCK]  = seg_sum;
      end

      // Stage control and partial-sum register; bubbles shift like data.
      always_ff @(posedge clk or posedge rst) begin
         // NOTE: non-blocking assignments for all state so every stage
         // samples its predecessor's pre-edge value.
         if (rst) begin
            st_q[k].valid <= 1'b0;
            st_q[k].carry <= 1'b0;
            sum_q[k]      <= '0;
         end else if (adv) begin
            st_q[k].valid <= v_src;
            st_q[k].carry <= seg_cout;
            sum_q[k]      <= sum_nxt;
         end
      end

      // Operand skew registers carry the upper segments to later stages.
      always_ff @(posedge clk) begin
         // NOTE: no reset on operand skew registers; their content is only
         // consumed alongside a set valid bit, which reset does clear.
         if (adv) begin
            a_q[k] <= a_src;
            b_q[k] <= b_src;
         end
      end

      if (k == NUM_BLK - 1) begin : g_tail
         // Signed overflow: carry into MSB (a^b^sum at MSB) XOR carry out.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ seg_sum[BLOCK-1] ^ seg_cout;
            end
         end
      end
   end

   assign out_valid = st_q[NUM_BLK-1].valid;
   assign out_sum   = sum_q[NUM_BLK-1];
   assign out_cout  = st_q[NUM_BLK-1].carry;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench for pipelined_carry_select_adder (scoreboard based).
// Main instance WIDTH=32/BLOCK=8; three extra instances cover the parameter sweep.
module tb_pipelined_carry_select_adder;

   localparam int W   = 32;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main DUT signals
   logic          in_valid = 1'b0, in_ready, in_cin = 1'b0, in_sub = 1'b0;
   logic [W-1:0]  in_a = '0, in_b = '0, out_sum;
   logic          out_valid, out_ready = 1'b1, out_cout, out_ovf;

   // Sweep DUT signals (shared stimulus, independent outputs)
   logic          sw_valid = 1'b0, sw_cin = 1'b0;
   logic [63:0]   sw_a = '0, sw_b = '0;
   logic [15:0]   s0_sum, s1_sum;
   logic [63:0]   s2_sum;
   logic          s0_v, s1_v, s2_v, s0_c, s1_c, s2_c;
   logic          s0_r, s1_r, s2_r, s0_o, s1_o, s2_o;

   pipelined_carry_select_adder #(.WIDTH(W), .BLOCK(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef CSA_SUB_EN
      .in_sub(in_sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .out_ovf(out_ovf));

   pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(16)) dut_16x16 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s0_r),
      .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_cin(sw_cin),
`ifdef CSA_SUB_EN
      .in_sub(1'b0),
`endif
      .out_valid(s0_v), .out_ready(1'b1), .out_sum(s0_sum),
      .out_cout(s0_c), .out_ovf(s0_o));

   pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4)) dut_16x4 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s1_r),
      .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_cin(sw_cin),
`ifdef CSA_SUB_EN
      .in_sub(1'b0),
`endif
      .out_valid(s1_v), .out_ready(1'b1), .out_sum(s1_sum),
      .out_cout(s1_c), .out_ovf(s1_o));

   pipelined_carry_select_adder #(.WIDTH(64), .BLOCK(8)) dut_64x8 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s2_r),
      .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin),
`ifdef CSA_SUB_EN
      .in_sub(1'b0),
`endif
      .out_valid(s2_v), .out_ready(1'b1), .out_sum(s2_sum),
      .out_cout(s2_c), .out_ovf(s2_o));

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   typedef struct {
      logic [64:0] val;  // {cout, sum} zero-extended
      int          cyc;
   } sw_exp_t;

   exp_t    sb[$];
   sw_exp_t q0[$], q1[$], q2[$];
   int      n_checks = 0;
   int      n_fail   = 0;
   int      cyc      = 0;
   bit      check_lat = 1'b0;

   // Reference model for the main 32-bit instance.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t         e;
      logic [W-1:0] be;
      logic         ci;
      logic [W:0]   r;
      be     = sub ? ~b : b;
      ci     = sub ? 1'b1 : cin;
      r      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
      e.sum  = r[W-1:0];
      e.cout = r[W];
      e.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
      e.cyc  = 0;
      return e;
   endfunction

   // One clock cycle on the main DUT: drive, push accepted operands to the
   // scoreboard, pop/compare any delivered result, then advance one cycle.
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic rdy, output bit acc);
      exp_t e;
      in_valid = v; in_a = a; in_b = b; in_cin = cin; in_sub = sub; out_ready = rdy;
      #1;
      acc = v && in_ready;
      if (out_valid && out_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got sum=%h cout=%b, required no output", out_sum, out_cout);
         end else begin
            e = sb.pop_front();
            if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
               n_fail++;
               $display("FAIL result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                        out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
            end
            if (check_lat) begin
               n_checks++;
               if (cyc - e.cyc !== LAT) begin
                  n_fail++;
                  $display("FAIL latency: got %0d, required %0d", cyc - e.cyc, LAT);
               end
            end
         end
      end
      if (acc) begin
         e = model(a, b, cin, sub);
         e.cyc = cyc;
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain(input int bound);
      bit acc;
      for (int k = 0; k < bound && sb.size() > 0; k++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
      end
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, required all 0",
                  out_valid, out_sum, out_cout, out_ovf);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_carry_chain;
      bit acc;
      int lat;
      check_lat = 1'b1;
      step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, acc);
      lat = 1;
      while (!out_valid && lat < 20) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
         lat++;
      end
      n_checks++;
      if (lat !== LAT) begin
         n_fail++;
         $display("FAIL carry_latency: got %0d cycles, required %0d", lat, LAT);
      end
      drain(10);
   endtask

   task automatic test_streaming;
      bit acc;
      check_lat = 1'b1;
      step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, acc);
      step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, acc);
      step(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, acc);
      drain(12);
   endtask

   task automatic test_backpressure;
      bit           acc;
      int           idx;
      logic [W+1:0] snap;
      check_lat = 1'b0;
      idx = 0;
      for (int g = 0; g < 20 && !out_valid; g++) begin
         step(idx < 6, 32'h1000_0000 * (idx + 1), 32'h0F0F_0F0F + idx, idx[0], 1'b0, 1'b1, acc);
         if (acc) idx++;
      end
      snap = {out_sum, out_cout, out_ovf};
      for (int s = 0; s < 5; s++) begin
         step(idx < 6, 32'h1000_0000 * (idx + 1), 32'h0F0F_0F0F + idx, idx[0], 1'b0, 1'b0, acc);
         if (acc) idx++;
         n_checks++;
         if ({out_valid, in_ready, out_sum, out_cout, out_ovf} !== {1'b1, 1'b0, snap}) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b in_ready=%b out=%h, required valid=1 in_ready=0 out=%h",
                     out_valid, in_ready, {out_sum, out_cout, out_ovf}, snap);
         end
      end
      for (int g = 0; g < 20 && idx < 6; g++) begin
         step(1'b1, 32'h1000_0000 * (idx + 1), 32'h0F0F_0F0F + idx, idx[0], 1'b0, 1'b1, acc);
         if (acc) idx++;
      end
      drain(12);
   endtask

   task automatic test_reset_midflight;
      bit acc;
      check_lat = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 32'h0101_0101 * (i + 1), 32'h2000_0003, 1'b0, 1'b0, 1'b1, acc);
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_valid: got %b, required 1", out_valid);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midflight_reset: got valid=%b sum=%h cout=%b ovf=%b, required all 0",
                  out_valid, out_sum, out_cout, out_ovf);
      end
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
   endtask

   task automatic test_subtract;
`ifdef CSA_SUB_EN
      bit acc;
      check_lat = 1'b1;
      step(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1, acc);
      step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, acc);
      step(1'b1, 32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1, 1'b1, acc);
      drain(12);
`endif
   endtask

   task automatic test_random;
      bit acc;
      check_lat = 1'b0;
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
`ifdef CSA_SUB_EN
              1'($urandom),
`else
              1'b0,
`endif
              1'($urandom_range(0, 3) != 0), acc);
      drain(20);
   endtask

   task automatic test_param_sweep;
      sw_exp_t e;
      logic [16:0] r16;
      logic [64:0] r64;
      for (int t = 0; t < 62; t++) begin
         sw_valid = (t < 50) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
         sw_a = {$urandom, $urandom};
         sw_b = {$urandom, $urandom};
         sw_cin = 1'($urandom);
         #1;
         if (s0_v) begin
            n_checks += 2;
            if (q0.size() == 0) begin
               n_fail++; $display("FAIL sweep16x16_extra: got sum=%h, required no output", s0_sum);
            end else begin
               e = q0.pop_front();
               if ({s0_c, s0_sum} !== e.val[16:0]) begin
                  n_fail++; $display("FAIL sweep16x16: got %h, required %h", {s0_c, s0_sum}, e.val[16:0]);
               end
               if (t - e.cyc !== 1) begin
                  n_fail++; $display("FAIL sweep16x16_latency: got %0d, required 1", t - e.cyc);
               end
            end
         end
         if (s1_v) begin
            n_checks += 2;
            if (q1.size() == 0) begin
               n_fail++; $display("FAIL sweep16x4_extra: got sum=%h, required no output", s1_sum);
            end else begin
               e = q1.pop_front();
               if ({s1_c, s1_sum} !== e.val[16:0]) begin
                  n_fail++; $display("FAIL sweep16x4: got %h, required %h", {s1_c, s1_sum}, e.val[16:0]);
               end
               if (t - e.cyc !== 4) begin
                  n_fail++; $display("FAIL sweep16x4_latency: got %0d, required 4", t - e.cyc);
               end
            end
         end
         if (s2_v) begin
            n_checks += 2;
            if (q2.size() == 0) begin
               n_fail++; $display("FAIL sweep64x8_extra: got sum=%h, required no output", s2_sum);
            end else begin
               e = q2.pop_front();
               if ({s2_c, s2_sum} !== e.val) begin
                  n_fail++; $display("FAIL sweep64x8: got %h, required %h", {s2_c, s2_sum}, e.val);
               end
               if (t - e.cyc !== 8) begin
                  n_fail++; $display("FAIL sweep64x8_latency: got %0d, required 8", t - e.cyc);
               end
            end
         end
         if (sw_valid) begin
            r16 = {1'b0, sw_a[15:0]} + {1'b0, sw_b[15:0]} + {16'h0, sw_cin};
            r64 = {1'b0, sw_a} + {1'b0, sw_b} + {64'h0, sw_cin};
            e.cyc = t;
            e.val = {48'h0, r16};
            q0.push_back(e);
            q1.push_back(e);
            e.val = r64;
            q2.push_back(e);
         end
         @(posedge clk);
         @(negedge clk);
      end
      n_checks++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         n_fail++;
         $display("FAIL sweep_drain: got %0d pending, required 0", q0.size() + q1.size() + q2.size());
      end
   endtask

   initial begin
      test_reset();
      test_carry_chain();
      test_streaming();
      test_backpressure();
      test_reset_midflight();
      test_subtract();
      test_random();
      test_param_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
